// File: rtl/eth_rx_byte_framer_if.sv
// Byte-stream bundle between the PHY/MAC byte interface and eth_rx_byte_framer.
// master drives raw receive bytes; slave is the framer returning framed bytes and status.
interface eth_rx_byte_framer_if;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic [7:0]  eth_data;
  logic [7:0]  cnt;
  logic        data_valid;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        runt;
  logic        udp_frame;

  modport master (
    output rx_data, rx_dv,
    input  eth_data, cnt, data_valid, frame_done, frame_len, runt, udp_frame
  );

  modport slave (
    input  rx_data, rx_dv,
    output eth_data, cnt, data_valid, frame_done, frame_len, runt, udp_frame
  );
endinterface

// File: rtl/eth_rx_byte_framer.sv
// Strips preamble/SFD from the PHY byte stream; presents frame bytes with index, length and runt status.
// Latency 1 cycle rx_data -> eth_data; no backpressure, the PHY stream cannot be stalled.
// UDP_FILTER_EN adds IPv4/UDP header recognition on udp_frame (tied 0 otherwise).
module eth_rx_byte_framer #(
  parameter int MIN_LEN = 60,
  parameter int MAX_PRE = 7
) (
  input logic                 clk,
  input logic                 reset,
  eth_rx_byte_framer_if.slave rx
);
  localparam int PW = $clog2(MAX_PRE + 1);
  localparam logic [PW-1:0] PRE_LIMIT = PW'(MAX_PRE);
  localparam logic [15:0]   MIN_LEN_W = 16'(MIN_LEN);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]    eth_data_q, eth_data_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_len_q, frame_len_d;
  logic          runt_q, runt_d;

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    eth_data_d   = eth_data_q;
    cnt_d        = cnt_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    runt_d       = runt_q;
    case (state_q)
      IDLE: begin
        if (rx.rx_dv) begin
          if (rx.rx_data == 8'h55) begin
            state_d   = PRE;
            pre_cnt_d = PW'(1);
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!rx.rx_dv) begin
          state_d = IDLE;
        end else if (rx.rx_data == 8'hD5) begin
          state_d    = DATA;
          byte_cnt_d = '0;
        end else if (rx.rx_data == 8'h55 && pre_cnt_q < PRE_LIMIT) begin
          pre_cnt_d = pre_cnt_q + PW'(1);
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx.rx_dv) begin
          eth_data_d   = rx.rx_data;
          // cnt is only a field index for decoders, so it pins at 255 on long frames
          cnt_d        = (byte_cnt_q > 16'd255) ? 8'hFF : byte_cnt_q[7:0];
          data_valid_d = 1'b1;
          if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
        end else begin
          frame_done_d = 1'b1;
          frame_len_d  = byte_cnt_q;
          runt_d       = (byte_cnt_q < MIN_LEN_W);
          state_d      = IDLE;
        end
      end
      DROP: begin
        if (!rx.rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      eth_data_q   <= '0;
      cnt_q        <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      runt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      eth_data_q   <= eth_data_d;
      cnt_q        <= cnt_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      runt_q       <= runt_d;
    end
  end

  assign rx.eth_data   = eth_data_q;
  assign rx.cnt        = cnt_q;
  assign rx.data_valid = data_valid_q;
  assign rx.frame_done = frame_done_q;
  assign rx.frame_len  = frame_len_q;
  assign rx.runt       = runt_q;

`ifdef UDP_FILTER_EN
  // hit bits: ethertype hi/lo, IPv4 version/IHL, IP protocol; cleared at SFD so short frames fail
  logic [3:0] hit_q, hit_d;
  logic       udp_frame_q, udp_frame_d;

  always_comb begin
    hit_d       = hit_q;
    udp_frame_d = udp_frame_q;
    if (state_q == PRE && rx.rx_dv && rx.rx_data == 8'hD5) begin
      hit_d       = '0;
      udp_frame_d = 1'b0;
    end else if (state_q == DATA) begin
      if (rx.rx_dv) begin
        case (byte_cnt_q)
          16'd12:  hit_d[0] = (rx.rx_data == 8'h08);
          16'd13:  hit_d[1] = (rx.rx_data == 8'h00);
          16'd14:  hit_d[2] = (rx.rx_data == 8'h45);
          16'd23:  hit_d[3] = (rx.rx_data == 8'h11);
          default: ;
        endcase
      end else begin
        udp_frame_d = &hit_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q       <= '0;
      udp_frame_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      udp_frame_q <= udp_frame_d;
    end
  end

  assign rx.udp_frame = udp_frame_q;
`else
  assign rx.udp_frame = 1'b0;
`endif
endmodule
